// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings, default latencies
// and small op-classification helpers.
package md_unit_pkg;

  localparam int MD_OP_W = 3;
  localparam int CNT_W   = 5;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 3'd6;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 3'd7;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // mult/multu/div/divu occupy the lower half of the encoding space
  function automatic logic is_arith_op(input logic [MD_OP_W-1:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational arithmetic core: 64-bit signed/unsigned product and quotient/remainder,
// plus a divide-by-zero flag for div/divu.
module md_calc
  import md_unit_pkg::*;
(
  input  logic [MD_OP_W-1:0] op_i,
  input  logic [31:0]        a_i,
  input  logic [31:0]        b_i,
  output logic [31:0]        hi_o,
  output logic [31:0]        lo_o,
  output logic               div_by_zero_o
);

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0] sq_mag, sr_mag, sq, sr, uq, ur;

  // Low 64 bits of a 64x64 product of sign-extended operands equal the signed product
  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  assign b_zero = (b_i == 32'd0);
  assign a_neg  = a_i[31];
  assign b_neg  = b_i[31];
  assign a_mag  = a_neg ? (32'd0 - a_i) : a_i;
  assign b_mag  = b_neg ? (32'd0 - b_i) : b_i;

  // A dummy divisor of 1 keeps the dividers X-free; the result is discarded on zero.
  assign b_mag_safe = b_zero ? 32'd1 : b_mag;
  assign b_safe     = b_zero ? 32'd1 : b_i;

  // Signed divide on magnitudes; 0x80000000 / -1 naturally yields 0x80000000 rem 0.
  assign sq_mag = a_mag / b_mag_safe;
  assign sr_mag = a_mag % b_mag_safe;
  assign sq     = (a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag;
  assign sr     = a_neg ? (32'd0 - sr_mag) : sr_mag;

  assign uq = a_i / b_safe;
  assign ur = a_i % b_safe;

  always_comb begin
    hi_o = 32'd0;
    lo_o = 32'd0;
    case (op_i)
      MD_MULT:  {hi_o, lo_o} = prod_s;
      MD_MULTU: {hi_o, lo_o} = prod_u;
      MD_DIV: begin
        hi_o = sr;
        lo_o = sq;
      end
      MD_DIVU: begin
        hi_o = ur;
        lo_o = uq;
      end
      default: begin
        hi_o = 32'd0;
        lo_o = 32'd0;
      end
    endcase
  end

  assign div_by_zero_o = is_div_op(op_i) && b_zero;

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; exposes busy_cnt so the hazard unit
// can stall md-class instructions until the pending result has been committed.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        rs_val,
  input  logic [31:0]        rt_val,
  output logic [31:0]        hi,
  output logic [31:0]        lo,
  output logic [31:0]        md_rdata,
  output logic               busy,
  output logic [CNT_W-1:0]   busy_cnt
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;

  logic [31:0] calc_hi, calc_lo;
  logic        calc_dz;

  md_calc u_calc (
    .op_i          (md_op),
    .a_i           (rs_val),
    .b_i           (rt_val),
    .hi_o          (calc_hi),
    .lo_o          (calc_lo),
    .div_by_zero_o (calc_dz)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start && is_arith_op(md_op)) begin
          pend_hi_d = calc_hi;
          pend_lo_d = calc_lo;
          pend_dz_d = calc_dz;
          cnt_d     = is_div_op(md_op) ? DIV_LOAD : MULT_LOAD;
          state_d   = ST_RUN;
        end else if (md_op == MD_MTHI) begin
          hi_d = rs_val;
        end else if (md_op == MD_MTLO) begin
          lo_d = rs_val;
        end
      end
      ST_RUN: begin
        // Everything arriving during RUN, including a stray start, is ignored
        if (cnt_q == CNT_W'(1)) begin
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy_cnt = cnt_q;
  assign busy     = (cnt_q != '0);
  assign md_rdata = (md_op == MD_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: expected HI/LO pairs are queued at accept and
// popped when busy_cnt reaches zero.
module tb_md_unit;
  import md_unit_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi, lo, md_rdata;
  logic        busy;
  logic [4:0]  busy_cnt;

  int   n_vec;
  int   n_err;
  res_t sb[$];
  logic [31:0] cur_hi, cur_lo;

  md_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .hi       (hi),
    .lo       (lo),
    .md_rdata (md_rdata),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept an arithmetic op and queue its expected commit value
  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input res_t exp, input int cnt_exp, input string name);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    sb.push_back(exp);
    tick();
    start = 1'b0;
    md_op = MD_MFLO;
    n_vec++;
    if (busy_cnt !== 5'(cnt_exp) || busy !== 1'b1 || hi !== cur_hi || lo !== cur_lo) begin
      n_err++;
      $display("FAIL %s accept: cnt=%0d busy=%b hi=%h lo=%h, expected cnt=%0d busy=1 hi=%h lo=%h",
               name, busy_cnt, busy, hi, lo, cnt_exp, cur_hi, cur_lo);
    end
  endtask

  // Step through the remaining RUN cycles, then pop and compare the committed result
  task automatic run_commit(input int cnt_now, input string name);
    res_t exp;
    for (int k = cnt_now - 1; k >= 1; k--) begin
      tick();
      n_vec++;
      if (busy_cnt !== 5'(k) || hi !== cur_hi || lo !== cur_lo) begin
        n_err++;
        $display("FAIL %s run: cnt=%0d hi=%h lo=%h, expected cnt=%0d hi=%h lo=%h",
                 name, busy_cnt, hi, lo, k, cur_hi, cur_lo);
      end
    end
    tick();
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s commit: scoreboard empty", name);
    end else begin
      exp = sb.pop_front();
      if (busy_cnt !== 5'd0 || busy !== 1'b0 || hi !== exp.hi || lo !== exp.lo) begin
        n_err++;
        $display("FAIL %s commit: cnt=%0d busy=%b hi=%h lo=%h, expected cnt=0 busy=0 hi=%h lo=%h",
                 name, busy_cnt, busy, hi, lo, exp.hi, exp.lo);
      end
      cur_hi = exp.hi;
      cur_lo = exp.lo;
      $display("txn %s: hi=%h lo=%h", name, hi, lo);
    end
  endtask

  task automatic write_hilo(input logic [2:0] op, input logic [31:0] val, input string name);
    md_op  = op;
    rs_val = val;
    tick();
    md_op = MD_MFLO;
    if (op == MD_MTHI) cur_hi = val;
    else               cur_lo = val;
    n_vec++;
    if (hi !== cur_hi || lo !== cur_lo) begin
      n_err++;
      $display("FAIL %s: hi=%h lo=%h, expected hi=%h lo=%h", name, hi, lo, cur_hi, cur_lo);
    end
    $display("txn %s: hi=%h lo=%h", name, hi, lo);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    n_vec++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy_cnt !== 5'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset: hi=%h lo=%h cnt=%0d busy=%b, expected all zero", hi, lo, busy_cnt, busy);
    end
    $display("txn reset: hi=%h lo=%h cnt=%0d", hi, lo, busy_cnt);
  endtask

  task automatic test_mult();
    accept(MD_MULT, 32'hFFFF_FFFD, 32'd5, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF1}, 5, "mult");
    run_commit(5, "mult");
    accept(MD_MULTU, 32'hFFFF_FFFF, 32'd2, '{hi: 32'h0000_0001, lo: 32'hFFFF_FFFE}, 5, "multu");
    run_commit(5, "multu");
  endtask

  task automatic test_div();
    accept(MD_DIV, 32'hFFFF_FFF9, 32'd2, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD}, 10, "div");
    run_commit(10, "div");
    accept(MD_DIVU, 32'd7, 32'd2, '{hi: 32'd1, lo: 32'd3}, 10, "divu");
    run_commit(10, "divu");
    accept(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '{hi: 32'd0, lo: 32'h8000_0000}, 10, "div_ovf");
    run_commit(10, "div_ovf");
  endtask

  task automatic test_div_zero();
    write_hilo(MD_MTHI, 32'h0000_1234, "mthi");
    accept(MD_DIV, 32'd99, 32'd0, '{hi: 32'h0000_1234, lo: cur_lo}, 10, "div_zero");
    run_commit(10, "div_zero");
  endtask

  task automatic test_ignore_busy();
    accept(MD_MULT, 32'd3, 32'd4, '{hi: 32'd0, lo: 32'd12}, 5, "mult_first");
    start  = 1'b1;
    md_op  = MD_MULT;
    rs_val = 32'd100;
    rt_val = 32'd100;
    tick();
    start = 1'b0;
    n_vec++;
    if (busy_cnt !== 5'd4) begin
      n_err++;
      $display("FAIL start_busy: cnt=%0d, expected 4", busy_cnt);
    end
    md_op  = MD_MTLO;
    rs_val = 32'hDEAD;
    tick();
    n_vec++;
    if (busy_cnt !== 5'd3 || lo !== cur_lo) begin
      n_err++;
      $display("FAIL mtlo_busy: cnt=%0d lo=%h, expected cnt=3 lo=%h", busy_cnt, lo, cur_lo);
    end
    md_op  = MD_MTHI;
    rs_val = 32'hBEEF;
    tick();
    md_op = MD_MFLO;
    n_vec++;
    if (busy_cnt !== 5'd2 || hi !== cur_hi) begin
      n_err++;
      $display("FAIL mthi_busy: cnt=%0d hi=%h, expected cnt=2 hi=%h", busy_cnt, hi, cur_hi);
    end
    run_commit(2, "mult_first");
  endtask

  task automatic test_reset_mid();
    accept(MD_MULT, 32'd7, 32'd9, '{hi: 32'd0, lo: 32'd63}, 5, "mult_rst");
    tick();
    tick();
    n_vec++;
    if (busy_cnt !== 5'd3) begin
      n_err++;
      $display("FAIL reset_mid_pre: cnt=%0d, expected 3", busy_cnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    n_vec++;
    if (busy_cnt !== 5'd0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid: cnt=%0d hi=%h lo=%h, expected 0 0 0", busy_cnt, hi, lo);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (busy_cnt !== 5'd0 || hi !== 32'd0 || lo !== 32'd0) begin
        n_err++;
        $display("FAIL reset_no_commit: cyc=%0d cnt=%0d hi=%h lo=%h, expected 0 0 0",
                 i, busy_cnt, hi, lo);
      end
    end
    $display("txn reset_mid: hi=%h lo=%h cnt=%0d", hi, lo, busy_cnt);
  endtask

  task automatic test_rdata();
    write_hilo(MD_MTHI, 32'h0000_AAAA, "mthi_rd");
    write_hilo(MD_MTLO, 32'h0000_5555, "mtlo_rd");
    md_op = MD_MFHI;
    #1;
    n_vec++;
    if (md_rdata !== 32'h0000_AAAA) begin
      n_err++;
      $display("FAIL mfhi: md_rdata=%h, expected 0000aaaa", md_rdata);
    end
    md_op = MD_MFLO;
    #1;
    n_vec++;
    if (md_rdata !== 32'h0000_5555) begin
      n_err++;
      $display("FAIL mflo: md_rdata=%h, expected 00005555", md_rdata);
    end
    md_op = MD_DIV;
    #1;
    n_vec++;
    if (md_rdata !== 32'h0000_5555) begin
      n_err++;
      $display("FAIL rdata_other: md_rdata=%h, expected 00005555", md_rdata);
    end
    md_op = MD_MFLO;
    $display("txn rdata: hi=%h lo=%h", hi, lo);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    md_op  = MD_MFLO;
    rs_val = 32'd0;
    rt_val = 32'd0;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_busy();
    test_reset_mid();
    test_rdata();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
